// File: rtl/alu_result_stage.sv
// Registered result stage behind the signed adder: 2-entry skid buffer,
// sticky overflow and saturating overflow counter. Optional clamp: ALU_RESULT_SAT_EN.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_of,
  input  logic             in_cf,
  input  logic             in_zf,
  input  logic             in_nf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_flags,
  output logic             sticky_of,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int EW = WIDTH + 4;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [EW-1:0]    main_q, main_d;
  logic [EW-1:0]    skid_q, skid_d;
  logic [EW-1:0]    in_word;
  logic             in_ready_q, out_valid_q;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, emit;

  assign accept = in_valid && in_ready_q;
  assign emit   = out_valid_q && out_ready;

`ifdef ALU_RESULT_SAT_EN
  // MSB=1 on overflow means the true result was positive.
  always_comb begin
    in_word = {in_nf, in_zf, in_cf, in_of, in_sum};
    if (in_of) begin
      if (in_sum[WIDTH-1])
        in_word = {2'b00, in_cf, in_of, 1'b0, {(WIDTH-1){1'b1}}};
      else
        in_word = {2'b10, in_cf, in_of, 1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign in_word = {in_nf, in_zf, in_cf, in_of, in_sum};
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = in_word;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && !emit) begin
          skid_d  = in_word;
          state_d = S_TWO;
        end else if (accept && emit) begin
          main_d  = in_word;
        end else if (emit) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Set has priority over clear.
  assign sticky_d = (sticky_q && !sticky_clr) || (accept && in_of);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && in_of && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != S_TWO);
      out_valid_q <= (state_d != S_EMPTY);
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q[WIDTH-1:0];
  assign out_flags = main_q[EW-1:WIDTH];
  assign sticky_of = sticky_q;
  assign ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic
// against a queue-based model of the result FIFO and counters.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_sum;
  logic [3:0]  in_f;
  logic        out_ready;
  logic        sticky_clr;

  logic        in_ready, out_valid, sticky_of;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [15:0] ovf_count;

  logic        b_in_ready, b_out_valid, b_sticky;
  logic [31:0] b_out_data;
  logic [3:0]  b_out_flags;
  logic [1:0]  b_cnt;

  int tests = 0;
  int fails = 0;

  logic [35:0] mq[$];
  logic        m_sticky;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum),
    .in_of(in_f[0]), .in_cf(in_f[1]), .in_zf(in_f[2]), .in_nf(in_f[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags),
    .sticky_of(sticky_of), .sticky_clr(sticky_clr),
    .ovf_count(ovf_count)
  );

  alu_result_stage #(.WIDTH(32), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sum(in_sum),
    .in_of(in_f[0]), .in_cf(in_f[1]), .in_zf(in_f[2]), .in_nf(in_f[3]),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_flags(b_out_flags),
    .sticky_of(b_sticky), .sticky_clr(sticky_clr),
    .ovf_count(b_cnt)
  );

  function automatic logic [35:0] stored(logic [31:0] s, logic [3:0] f);
`ifdef ALU_RESULT_SAT_EN
    if (f[0]) begin
      if (s[31]) return {2'b00, f[1], 1'b1, 32'h7FFF_FFFF};
      return {2'b10, f[1], 1'b1, 32'h8000_0000};
    end
`endif
    return {f, s};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sticky = 1'b0;
    m_cnt    = 0;
    m_cnt2   = 0;
  endtask

  // One clock: drive at negedge, check model state, advance model at posedge.
  task automatic cycle(input logic v, input logic [31:0] s,
                       input logic [3:0] f, input logic ordy,
                       input logic clr);
    logic acc, emt;
    @(negedge clk);
    in_valid   = v;
    in_sum     = s;
    in_f       = f;
    out_ready  = ordy;
    sticky_clr = clr;
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(mq[0][31:0]));
      chk("out_flags", 64'(out_flags), 64'(mq[0][35:32]));
    end
    chk("sticky_of", 64'(sticky_of), 64'(m_sticky));
    chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
    chk("ovf_count_c2", 64'(b_cnt), 64'(m_cnt2));
    acc = v && (mq.size() < 2);
    emt = ordy && (mq.size() > 0);
    @(posedge clk);
    if (emt) void'(mq.pop_front());
    if (acc) mq.push_back(stored(s, f));
    m_sticky = (m_sticky && !clr) || (acc && f[0]);
    if (acc && f[0]) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  initial begin
    int exp_c2 [5];
    exp_c2 = '{1, 2, 3, 3, 3};
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_f = '0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_sticky", 64'(sticky_of), 64'd0);
    chk("rst_count", 64'(ovf_count), 64'd0);
    rst_n = 1'b1;

    // single transfer, one-cycle latency
    cycle(1'b1, 32'h5, 4'b0000, 1'b1, 1'b0);
    #1;
    chk("lat_data", 64'(out_data), 64'h5);
    chk("lat_flags", 64'(out_flags), 64'h0);
    chk("lat_ready", 64'(in_ready), 64'd1);
    cycle(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

    // backpressure then drain in order
    cycle(1'b1, 32'h11, 4'b0000, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 4'b0000, 1'b0, 1'b0);
    #1;
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    cycle(1'b1, 32'h33, 4'b0000, 1'b1, 1'b0);
    #1;
    chk("bp_second", 64'(out_data), 64'h22);
    cycle(1'b1, 32'h33, 4'b0000, 1'b1, 1'b0);
    #1;
    chk("bp_third", 64'(out_data), 64'h33);
    cycle(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

    // overflow capture
    cycle(1'b1, 32'h8000_0000, 4'b1001, 1'b1, 1'b0);
    #1;
`ifdef ALU_RESULT_SAT_EN
    chk("ovf_data", 64'(out_data), 64'h7FFF_FFFF);
    chk("ovf_flags", 64'(out_flags), 64'b0001);
`else
    chk("ovf_data", 64'(out_data), 64'h8000_0000);
    chk("ovf_flags", 64'(out_flags), 64'b1001);
`endif
    chk("ovf_sticky", 64'(sticky_of), 64'd1);
    chk("ovf_count1", 64'(ovf_count), 64'd1);

    // sticky set wins over clear, then clear alone
    cycle(1'b1, 32'h0000_0001, 4'b0001, 1'b1, 1'b1);
    #1;
    chk("race_sticky", 64'(sticky_of), 64'd1);
    cycle(1'b0, 32'h0, 4'b0000, 1'b1, 1'b1);
    #1;
    chk("clr_sticky", 64'(sticky_of), 64'd0);

    // fill both entries, then reset mid-cycle
    cycle(1'b1, 32'hAA, 4'b0000, 1'b0, 1'b0);
    cycle(1'b1, 32'hBB, 4'b0000, 1'b0, 1'b0);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    repeat (3) cycle(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

    // counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, $urandom, 4'b0001, 1'b1, 1'b0);
      #1;
      chk("sat_cnt", 64'(b_cnt), 64'(exp_c2[i]));
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
    end
    repeat (3) cycle(1'b0, 32'h0, 4'b0000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
